serial_subtractor: RTL

- Bit-serial 4-bit subtractor (A − B) for the tile, the inverse-direction companion to the team's combinational half-adder block.
- Operands are loaded in parallel from the dedicated inputs and processed LSB-first, one bit per clock, through a single half/full-subtractor cell with a registered borrow.
- Difference, borrow-out, done and busy are presented on the dedicated outputs; the bidirectional pins are used as inputs only.

---
 rtl/serial_subtractor.sv | 128 ++++++++++++
 1 files changed

// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial A - B, LSB first, one bit per clock through a
// single full-subtractor cell with a registered borrow.
// Optional feature macro: SERIAL_SUB_ABS_EN (magnitude result plus sign bit).
module serial_subtractor #(
  parameter int WIDTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe,
  input  logic       ena
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic             start_q;
  logic             launch;
  logic             borrow;
  logic             borrow_nxt;
  logic             diff_bit;
  logic             last_step;
  logic             borrow_out_r;
  logic             sign;
  logic [1:0]       cnt;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] diff_sr;
  logic [WIDTH-1:0] final_diff;
  logic [WIDTH-1:0] result;
  logic [3:0]       diff_ext;
  logic             unused_ok;

  // A launch is a rising edge of start; holding start high does not relaunch.
  assign launch     = uio_in[0] & ~start_q;
  assign diff_bit   = a_sr[0] ^ b_sr[0] ^ borrow;
  assign borrow_nxt = (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & borrow);
  assign final_diff = {diff_bit, diff_sr[WIDTH-1:1]};
  assign last_step  = (state == SHIFT) && (cnt == 2'(WIDTH - 1));

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic: launches are only honoured outside SHIFT.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: if (launch) state_nxt = SHIFT;
      SHIFT:      if (last_step) state_nxt = DONE;
      default:    state_nxt = IDLE;
    endcase
  end

  // Operand load, serial subtract steps and result capture on entry to DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_q      <= 1'b0;
      cnt          <= 2'd0;
      borrow       <= 1'b0;
      a_sr         <= '0;
      b_sr         <= '0;
      diff_sr      <= '0;
      result       <= '0;
      borrow_out_r <= 1'b0;
    end else begin
      start_q <= uio_in[0];
      if ((state != SHIFT) && launch) begin
        a_sr   <= ui_in[WIDTH-1:0];
        b_sr   <= ui_in[4 +: WIDTH];
        borrow <= 1'b0;
        cnt    <= 2'd0;
      end else if (state == SHIFT) begin
        diff_sr <= final_diff;
        a_sr    <= a_sr >> 1;
        b_sr    <= b_sr >> 1;
        borrow  <= borrow_nxt;
        cnt     <= cnt + 2'd1;
        if (last_step) begin
          borrow_out_r <= borrow_nxt;
`ifdef SERIAL_SUB_ABS_EN
          result <= borrow_nxt ? -final_diff : final_diff;
`else
          result <= final_diff;
`endif
        end
      end
    end
  end

`ifdef SERIAL_SUB_ABS_EN
  // Sign flag follows the final borrow and only changes on entry to DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sign <= 1'b0;
    end else if (last_step) begin
      sign <= borrow_nxt;
    end
  end
`else
  assign sign = 1'b0;
`endif

  // Zero-extend the result so difference bits above WIDTH read 0.
  always_comb begin
    diff_ext             = '0;
    diff_ext[WIDTH-1:0]  = result;
  end

  assign uo_out    = {sign, (state == SHIFT), (state == DONE), borrow_out_r, diff_ext};
  assign uio_out   = 8'h00;
  assign uio_oe    = 8'h00;
  assign unused_ok = &{1'b0, ena, uio_in[7:1], ui_in};

endmodule
